// File: rtl/sha256_uart_pkg.sv
// sha256_uart_pkg: shared types and constants for the SHA-256 UART return path.
package sha256_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DIGEST_BYTES = 32;
  localparam int UART_FRAME_BITS = 10;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;
  localparam logic [7:0] HEX_ALPHA_BASE = 8'h61;
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return nib < 4'd10 ? HEX_DIGIT_BASE + {4'h0, nib} : HEX_ALPHA_BASE + {4'h0, nib} - 8'd10;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single-byte 8N1 serializer, LSB first, registered tx output.
// Ready is also raised in the last stop-bit cycle so frames can be chained with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte_data,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_tx
);
  import sha256_uart_pkg::*;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  tx_state_t r_state, w_next;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_data;
  logic r_tx, w_tick, w_load, w_tx_next;
  assign w_tick = r_baud == BAUD_MAX;
  assign o_byte_ready = r_state == IDLE || (r_state == STOP && w_tick);
  assign w_load = i_byte_valid && o_byte_ready;
  assign o_tx = r_tx;
  always_comb begin
    w_next = w_load ? START
           : r_state == IDLE ? IDLE
           : !w_tick ? r_state
           : r_state == START ? DATA
           : r_state == DATA ? (r_bit == 3'd7 ? STOP : DATA)
           : IDLE;
    // r_data shifts on the same edge a data bit ends, so look one bit ahead
    w_tx_next = w_next == START ? 1'b0
              : w_next == DATA ? ((r_state == DATA && w_tick) ? r_data[1] : r_data[0])
              : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud <= '0;
      r_bit <= '0;
      r_data <= '0;
      r_tx <= 1'b1;
    end else begin
      r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
      r_bit <= r_state == DATA ? (w_tick ? r_bit + 1'b1 : r_bit) : '0;
      r_data <= w_load ? i_byte_data : (r_state == DATA && w_tick) ? r_data >> 1 : r_data;
      r_tx <= w_tx_next;
    end
  end
endmodule

// File: rtl/sha256_digest_uart_tx.sv
// sha256_digest_uart_tx: serializes a 256-bit digest onto uart_tx as 8N1 frames, MSB byte first.
// Define SHA256_TX_HEX_ASCII_EN to send lowercase hex characters followed by CR LF instead.
module sha256_digest_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DIGEST_BYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest,
  input  logic         digest_valid,
  output logic         digest_ready,
  output logic         uart_tx,
  output logic         busy,
  output logic         done
);
  import sha256_uart_pkg::*;
`ifdef SHA256_TX_HEX_ASCII_EN
  localparam int SHIFT = 4;
  localparam int FRAMES = 2 * DIGEST_BYTES + 2;
`else
  localparam int SHIFT = 8;
  localparam int FRAMES = DIGEST_BYTES;
`endif
  localparam int IW = $clog2(FRAMES);
  localparam logic [IW-1:0] LAST = IW'(FRAMES - 1);
  logic r_busy, r_done;
  logic [IW-1:0] r_idx;
  logic [255:0] r_shift;
  logic [7:0] w_byte;
  logic w_byte_valid, w_byte_ready, w_cap, w_adv, w_last;
  assign w_last = r_idx == LAST;
  assign w_cap = digest_valid && digest_ready;
  assign w_adv = r_busy && w_byte_ready;
  // the first frame is fed straight from the input so its start bit follows the capture edge
  assign w_byte_valid = r_busy ? !w_last : digest_valid;
`ifdef SHA256_TX_HEX_ASCII_EN
  logic [3:0] w_nib;
  assign w_nib = r_busy ? r_shift[255:252] : digest[255:252];
  assign w_byte = (r_busy && r_idx == IW'(FRAMES - 3)) ? ASCII_CR
                : (r_busy && r_idx == IW'(FRAMES - 2)) ? ASCII_LF
                : hex_char(w_nib);
`else
  assign w_byte = r_busy ? r_shift[255:248] : digest[255:248];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_idx <= '0;
      r_shift <= '0;
    end else begin
      r_done <= w_adv && w_last;
      if (w_cap) begin
        r_busy <= 1'b1;
        r_idx <= '0;
        r_shift <= digest << SHIFT;
      end else if (w_adv) begin
        r_busy <= !w_last;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        r_shift <= r_shift << SHIFT;
      end
    end
  end
  assign digest_ready = !r_busy;
  assign busy = r_busy;
  assign done = r_done;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst(rst),
    .i_byte_data(w_byte),
    .i_byte_valid(w_byte_valid),
    .o_byte_ready(w_byte_ready),
    .o_tx(uart_tx)
  );
endmodule

// File: tb/tb_sha256_digest_uart_tx.sv
// tb_sha256_digest_uart_tx: directed bench decoding uart_tx frames against known SHA-256 digests.
module tb_sha256_digest_uart_tx;
  localparam int CPB = 4;
`ifdef SHA256_TX_HEX_ASCII_EN
  localparam int NF = 66;
`else
  localparam int NF = 32;
`endif
  localparam int FT = 10 * CPB;
  localparam int DT = NF * FT;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  logic clk = 1'b0, rst = 1'b1, digest_valid = 1'b0;
  logic [255:0] digest = '0;
  logic digest_ready, uart_tx, busy, done;
  int tests = 0, fails = 0, cyc = 0, stop_err = 0, n_done = 0;
  logic [7:0] rx_q[$];
  int st_q[$];

  sha256_digest_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .digest(digest), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        st_q.push_back(cyc);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) stop_err++;
        rx_q.push_back(b);
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [255:0] d, input int i);
`ifdef SHA256_TX_HEX_ASCII_EN
    logic [3:0] nib;
    if (i == 64) return 8'h0d;
    if (i == 65) return 8'h0a;
    nib = d[255 - 4 * i -: 4];
    return nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
`else
    return d[255 - 8 * i -: 8];
`endif
  endfunction

  function automatic int stream_errs(input logic [255:0] d, input int base);
    int e = 0;
    for (int i = 0; i < NF; i++)
      if (base + i >= rx_q.size() || rx_q[base + i] !== exp_byte(d, i)) e++;
    return e;
  endfunction

  function automatic int gap_errs(input int base, input int n);
    int e = 0;
    for (int i = 1; i < n; i++)
      if (base + i >= st_q.size() || st_q[base + i] - st_q[base + i - 1] != FT) e++;
    return e;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    st_q.delete();
    stop_err = 0;
  endtask

  task automatic send(input logic [255:0] d, output int cap);
    @(negedge clk);
    digest = d;
    digest_valid = 1'b1;
    @(negedge clk);
    digest_valid = 1'b0;
    digest = ~d;
    cap = cyc;
  endtask

  task automatic wait_done(output bit ok, output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < DT + 200 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; t = cyc; end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    tests++; if (digest_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", digest_ready); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || digest_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    tests++; if (bad != 0 || rx_q.size() != 0) begin fails++; $display("FAIL idle_hold got %0d bad cycles %0d frames want 0", bad, rx_q.size()); end
  endtask

  task automatic test_single();
    int cap, t;
    bit ok;
    clear_mon();
    send(D_ABC, cap);
    tests++; if (uart_tx !== 1'b0) begin fails++; $display("FAIL start_fall got %b want 0", uart_tx); end
    tests++; if (busy !== 1'b1 || digest_ready !== 1'b0) begin fails++; $display("FAIL busy_ready got %b%b want 10", busy, digest_ready); end
    wait_done(ok, t);
    tests++; if (!ok) begin fails++; $display("FAIL single_done_timeout got none want pulse"); end
    tests++; if (t - cap != DT) begin fails++; $display("FAIL single_done_time got %0d want %0d", t - cap, DT); end
    tests++; if (busy !== 1'b0 || digest_ready !== 1'b1) begin fails++; $display("FAIL done_cycle_state got %b%b want 01", busy, digest_ready); end
    repeat (5) @(negedge clk);
    tests++; if (rx_q.size() != NF) begin fails++; $display("FAIL single_count got %0d want %0d", rx_q.size(), NF); end
    tests++; if (stream_errs(D_ABC, 0) != 0) begin fails++; $display("FAIL single_stream got %0d bad bytes want 0", stream_errs(D_ABC, 0)); end
    tests++; if (st_q.size() == 0 || st_q[0] != cap || gap_errs(0, NF) != 0 || stop_err != 0) begin
      fails++; $display("FAIL single_framing got %0d gap errs %0d stop errs want 0", gap_errs(0, NF), stop_err); end
  endtask

  task automatic test_ignore();
    int cap, t, bad = 0, n0;
    bit ok;
    clear_mon();
    n0 = n_done;
    send(D_ABC, cap);
    repeat (300) @(negedge clk);
    digest = D_EMPTY;
    digest_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (digest_ready !== 1'b0) bad++;
    end
    digest_valid = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL ignore_ready got %0d high cycles want 0", bad); end
    wait_done(ok, t);
    repeat (20) @(negedge clk);
    tests++; if (!ok || n_done - n0 != 1) begin fails++; $display("FAIL ignore_done got %0d pulses want 1", n_done - n0); end
    tests++; if (rx_q.size() != NF || stream_errs(D_ABC, 0) != 0) begin
      fails++; $display("FAIL ignore_stream got %0d frames %0d bad want %0d frames 0 bad", rx_q.size(), stream_errs(D_ABC, 0), NF); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    bit ok1, ok2;
    clear_mon();
    @(negedge clk);
    digest = D_ABC;
    digest_valid = 1'b1;
    @(negedge clk);
    digest = D_EMPTY;
    wait_done(ok1, t1);
    @(negedge clk);
    digest_valid = 1'b0;
    tests++; if (!ok1 || uart_tx !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_capture got tx=%b busy=%b want 0 1", uart_tx, busy); end
    wait_done(ok2, t2);
    repeat (5) @(negedge clk);
    tests++; if (!ok2 || t2 - t1 != DT + 1) begin fails++; $display("FAIL b2b_done_gap got %0d want %0d", t2 - t1, DT + 1); end
    tests++; if (st_q.size() < NF + 1 || st_q[NF] != t1 + 1 || gap_errs(0, NF) != 0) begin fails++; $display("FAIL b2b_start_gap got %0d gap errs want 0", gap_errs(0, NF)); end
    tests++; if (rx_q.size() != 2 * NF || stream_errs(D_ABC, 0) != 0 || stream_errs(D_EMPTY, NF) != 0) begin
      fails++; $display("FAIL b2b_stream got %0d frames %0d/%0d bad want %0d frames", rx_q.size(), stream_errs(D_ABC, 0), stream_errs(D_EMPTY, NF), 2 * NF); end
  endtask

  task automatic test_reset_mid();
    int cap, n0, t;
    bit ok;
    clear_mon();
    send(D_EMPTY, cap);
    repeat (5 * FT + 15) @(negedge clk);
    n0 = n_done;
    rst = 1'b1;
    #1;
    tests++; if (uart_tx !== 1'b1 || busy !== 1'b0 || digest_ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_state got tx=%b busy=%b ready=%b done=%b want 1 0 1 0", uart_tx, busy, digest_ready, done); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    tests++; if (n_done != n0 || uart_tx !== 1'b1) begin fails++; $display("FAIL rst_mid_nodone got %0d pulses tx=%b want 0 1", n_done - n0, uart_tx); end
    clear_mon();
    send(D_ABC, cap);
    wait_done(ok, t);
    repeat (5) @(negedge clk);
    tests++; if (!ok || t - cap != DT || rx_q.size() != NF || stream_errs(D_ABC, 0) != 0) begin
      fails++; $display("FAIL rst_mid_resend got %0d frames %0d bad time %0d want %0d frames 0 bad time %0d", rx_q.size(), stream_errs(D_ABC, 0), t - cap, NF, DT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
